// File: rtl/cellrv32_npu_package.sv
// Shared NPU types and constants, including the instruction-writer FSM
// encoding and the word-select codes used on the register interface.
package cellrv32_npu_package;

    localparam int BYTE_WIDTH = 8;

    typedef logic [4*BYTE_WIDTH-1:0] word_t;
    typedef logic [2*BYTE_WIDTH-1:0] halfword_t;

    typedef enum logic [1:0] {
        EXP_LOW,
        EXP_MID,
        EXP_UP,
        COMMIT
    } npu_iw_state_t;

    localparam logic [1:0] IW_SEL_LOW = 2'd0;
    localparam logic [1:0] IW_SEL_MID = 2'd1;
    localparam logic [1:0] IW_SEL_UP  = 2'd2;

    // Select code the writer is waiting for in a given accepting state.
    function automatic logic [1:0] iw_expected_sel(input npu_iw_state_t s);
        logic [1:0] sel;
        case (s)
            EXP_LOW: sel = IW_SEL_LOW;
            EXP_MID: sel = IW_SEL_MID;
            default: sel = IW_SEL_UP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cellrv32_npu_instruction_writer.sv
// Stages LOW/MID/UP bus writes and issues one atomic three-lane push into the
// NPU instruction FIFO, holding off while the FIFO is full.
module cellrv32_npu_instruction_writer
    import cellrv32_npu_package::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_req_i,
    input  logic [1:0]           wr_sel_i,
    input  word_t                wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 flush_i,
    input  logic                 fifo_full_i,
    output word_t                low_word_o,
    output word_t                mid_word_o,
    output halfword_t            up_word_o,
    output logic [2:0]           wr_en_o,
    output logic                 seq_err_o,
    input  logic                 err_clr_i,
    output logic [CNT_WIDTH-1:0] issued_cnt_o,
    output npu_iw_state_t        state_o
);

    // Handshake: a write is taken in any cycle where wr_req_i & wr_ready_o;
    // the push is the single cycle where wr_en_o == 3'b111.

    npu_iw_state_t        state_q, state_d;
    word_t                low_q, low_d;
    word_t                mid_q, mid_d;
    halfword_t            up_q, up_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_set;
    logic [1:0]           exp_sel;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EXP_LOW;
            low_q   <= '0;
            mid_q   <= '0;
            up_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            mid_q   <= mid_d;
            up_q    <= up_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        low_d      = low_q;
        mid_d      = mid_q;
        up_d       = up_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        wr_en_o    = 3'b000;
        exp_sel    = iw_expected_sel(state_q);
        wr_ready_o = (state_q != COMMIT) && !flush_i;

        if (flush_i) begin
            state_d = EXP_LOW;
        end else if (state_q == COMMIT) begin
            if (!fifo_full_i) begin
                wr_en_o = 3'b111;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = EXP_LOW;
            end
        end else if (wr_req_i) begin
            if (wr_sel_i == 2'd3) begin
                err_set = 1'b1;
            end else if (wr_sel_i == exp_sel) begin
                case (wr_sel_i)
                    IW_SEL_LOW: begin
                        low_d   = wr_data_i;
                        state_d = EXP_MID;
                    end
                    IW_SEL_MID: begin
                        mid_d   = wr_data_i;
                        state_d = EXP_UP;
                    end
                    default: begin
                        up_d    = wr_data_i[15:0];
                        state_d = COMMIT;
                    end
                endcase
            end else begin
                // Out of order: a stray LOW restarts the instruction, anything else is dropped.
                err_set = 1'b1;
                if (wr_sel_i == IW_SEL_LOW) begin
                    low_d   = wr_data_i;
                    state_d = EXP_MID;
                end else begin
                    state_d = EXP_LOW;
                end
            end
        end

        err_d = err_set | (err_q & ~err_clr_i);
    end

    assign low_word_o   = low_q;
    assign mid_word_o   = mid_q;
    assign up_word_o    = up_q;
    assign seq_err_o    = err_q;
    assign issued_cnt_o = cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_cellrv32_npu_instruction_writer.sv
// Self-checking bench for the NPU instruction writer: directed scenarios plus
// random traffic compared against a word-progress model and a push scoreboard.
module tb_cellrv32_npu_instruction_writer;
    import cellrv32_npu_package::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_req;
    logic [1:0]       wr_sel;
    word_t            wr_data;
    logic             wr_ready;
    logic             flush;
    logic             fifo_full;
    word_t            low_word;
    word_t            mid_word;
    halfword_t        up_word;
    logic [2:0]       wr_en;
    logic             seq_err;
    logic             err_clr;
    logic [CNT_W-1:0] issued_cnt;
    npu_iw_state_t    state;

    int total = 0;
    int bad   = 0;

    // Reference model: number of words staged so far (3 = waiting to push).
    int          m_n;
    logic [31:0] m_low, m_mid;
    logic [15:0] m_up;
    bit          m_err;
    int          m_cnt;
    logic [79:0] exp_q[$];

    cellrv32_npu_instruction_writer #(.CNT_WIDTH(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_req_i    (wr_req),
        .wr_sel_i    (wr_sel),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .flush_i     (flush),
        .fifo_full_i (fifo_full),
        .low_word_o  (low_word),
        .mid_word_o  (mid_word),
        .up_word_o   (up_word),
        .wr_en_o     (wr_en),
        .seq_err_o   (seq_err),
        .err_clr_i   (err_clr),
        .issued_cnt_o(issued_cnt),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_n   = 0;
        m_low = '0;
        m_mid = '0;
        m_up  = '0;
        m_err = 1'b0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input bit fl, input bit full);
        bit e_ready;
        bit e_en;
        e_ready = (m_n < 3) && !fl;
        e_en    = (m_n == 3) && !fl && !full;
        check_eq("wr_ready", wr_ready, e_ready);
        check_eq("wr_en", wr_en, e_en ? 3'b111 : 3'b000);
        check_eq("low_word", low_word, m_low);
        check_eq("mid_word", mid_word, m_mid);
        check_eq("up_word", up_word, m_up);
        check_eq("seq_err", seq_err, m_err);
        check_eq("issued_cnt", issued_cnt, m_cnt);
        check_eq("state", state, npu_iw_state_t'(m_n));
        if (e_en) exp_q.push_back({m_low, m_mid, m_up});
        if (wr_en == 3'b111) begin
            if (exp_q.size() == 0) check_eq("push_unexpected", wr_en, 3'b000);
            else check_eq("push_data", {low_word, mid_word, up_word}, exp_q.pop_front());
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance model, cross the edge.
    task automatic step(input bit req, input logic [1:0] sel, input logic [31:0] data,
                        input bit fl, input bit full, input bit clr);
        bit set;
        wr_req    = req;
        wr_sel    = sel;
        wr_data   = data;
        flush     = fl;
        fifo_full = full;
        err_clr   = clr;
        @(negedge clk);
        check_outputs(fl, full);
        set = 1'b0;
        if (fl) begin
            m_n = 0;
        end else if (m_n == 3) begin
            if (!full) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_n   = 0;
            end
        end else if (req) begin
            if (sel == 2'd3) begin
                set = 1'b1;
            end else if (int'(sel) == m_n) begin
                if (sel == 2'd0) m_low = data;
                else if (sel == 2'd1) m_mid = data;
                else m_up = data[15:0];
                m_n++;
            end else begin
                set = 1'b1;
                if (sel == 2'd0) begin
                    m_low = data;
                    m_n   = 1;
                end else begin
                    m_n = 0;
                end
            end
        end
        m_err = set ? 1'b1 : (clr ? 1'b0 : m_err);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        step(1'b1, sel, data, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit full);
        step(1'b0, 2'd0, 32'h0, 1'b0, full, 1'b0);
    endtask

    task automatic do_reset();
        wr_req  = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b0, fifo_full);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic full_instr(input logic [31:0] lo, input logic [31:0] mi, input logic [31:0] up);
        wr(IW_SEL_LOW, lo);
        wr(IW_SEL_MID, mi);
        wr(IW_SEL_UP, up);
        idle(1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        wr_req    = 1'b0;
        wr_sel    = 2'd0;
        wr_data   = '0;
        flush     = 1'b0;
        fifo_full = 1'b0;
        err_clr   = 1'b0;
        model_reset();
        #1;
        check_outputs(1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        full_instr(32'h11111111, 32'h22222222, 32'hABCD1234);
        check_eq("first_cnt", issued_cnt, 1);
        check_eq("first_up", up_word, 16'h1234);

        wr(IW_SEL_LOW, 32'h11111111);
        wr(IW_SEL_MID, 32'h22222222);
        wr(IW_SEL_UP, 32'hABCD1234);
        repeat (5) idle(1'b1);
        idle(1'b0);
        check_eq("full_cnt", issued_cnt, 2);

        wr(IW_SEL_LOW, 32'h44444444);
        wr(IW_SEL_UP, 32'h55555555);
        check_eq("ooo_err", seq_err, 1'b1);
        check_eq("ooo_state", state, EXP_LOW);
        full_instr(32'h66666666, 32'h77777777, 32'h88889999);
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("err_clr", seq_err, 1'b0);

        wr(IW_SEL_LOW, 32'h11111111);
        wr(IW_SEL_MID, 32'h22222222);
        wr(IW_SEL_LOW, 32'h33333333);
        check_eq("relow_state", state, EXP_MID);
        wr(IW_SEL_MID, 32'hAAAAAAAA);
        wr(IW_SEL_UP, 32'h0000BBBB);
        idle(1'b0);
        check_eq("relow_cnt", issued_cnt, 4);
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        wr(IW_SEL_LOW, 32'h01010101);
        wr(IW_SEL_MID, 32'h02020202);
        wr(2'd3, 32'hDEADBEEF);
        wr(IW_SEL_UP, 32'h00000303);
        step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_eq("flush_cnt", issued_cnt, 4);
        check_eq("flush_state", state, EXP_LOW);

        wr(IW_SEL_LOW, 32'hCAFE0001);
        wr(IW_SEL_MID, 32'hCAFE0002);
        do_reset();
        check_eq("rst_low", low_word, 32'h0);
        idle(1'b0);

        while (m_cnt != (1 << CNT_W) - 1) full_instr($urandom, $urandom, $urandom);
        full_instr(32'h12345678, 32'h9ABCDEF0, 32'h0000F00D);
        check_eq("cnt_wrap", issued_cnt, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] sel;
            if (m_n < 3 && $urandom_range(0, 7) < 6) sel = 2'(m_n);
            else sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 3) != 0, sel, $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
        end

        idle(1'b0);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
